// File: rtl/apb_regbank_pkg.sv
// Shared definitions for the APB wait-state register bank completer.
//   - apb_cmp_state_t : completer FSM states (IDLE, ACCESS)
//   - OFF_*           : byte offsets of the register map within PADDR[4:0]
//   - reg_sel_t       : decoded register select
//   - decode_sel()    : maps an offset to a register select
package apb_regbank_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_cmp_state_t;

  localparam logic [4:0] OFF_REG0   = 5'h00;
  localparam logic [4:0] OFF_REG1   = 5'h04;
  localparam logic [4:0] OFF_REG2   = 5'h08;
  localparam logic [4:0] OFF_REG3   = 5'h0C;
  localparam logic [4:0] OFF_STATUS = 5'h10;
  localparam logic [4:0] OFF_ID     = 5'h14;

  // The low two bits of SEL_REG0..SEL_REG3 equal the register index.
  typedef enum logic [2:0] {
    SEL_REG0   = 3'd0,
    SEL_REG1   = 3'd1,
    SEL_REG2   = 3'd2,
    SEL_REG3   = 3'd3,
    SEL_STATUS = 3'd4,
    SEL_ID     = 3'd5,
    SEL_NONE   = 3'd7
  } reg_sel_t;

  function automatic reg_sel_t decode_sel(input logic [4:0] off);
    reg_sel_t sel;
    case (off)
      OFF_REG0:   sel = SEL_REG0;
      OFF_REG1:   sel = SEL_REG1;
      OFF_REG2:   sel = SEL_REG2;
      OFF_REG3:   sel = SEL_REG3;
      OFF_STATUS: sel = SEL_STATUS;
      OFF_ID:     sel = SEL_ID;
      default:    sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/apb_regbank.sv
// Register storage, transfer counters and address decode for the completer.
//   clk, rst   : clock, asynchronous active-high reset
//   commit     : one-cycle strobe at the edge a transfer completes
//   addr       : captured byte address
//   wdata      : captured write data
//   write      : captured direction (1 = write)
//   rdata      : read mux output for the captured address
//   err        : captured address/direction is an illegal access
//   reg_out    : {REG3, REG2, REG1, REG0}
module apb_regbank
  import apb_regbank_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = DATA_WIDTH'(32'hA9B0_0001)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      commit,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic                      write,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      err,
  output logic [4*DATA_WIDTH-1:0]   reg_out
);

  logic [DATA_WIDTH-1:0] regs [4];
  logic [7:0]            wr_cnt;
  logic [7:0]            rd_cnt;
  reg_sel_t              sel;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  ro_write;

  assign sel          = decode_sel(addr[4:0]);
  assign misaligned   = (addr[1:0] != 2'b00);
  assign out_of_range = (addr > ADDR_WIDTH'(OFF_ID));
  assign ro_write     = write && ((sel == SEL_STATUS) || (sel == SEL_ID));
  assign err          = misaligned || out_of_range || ro_write;

  // A legal write can only target REG0..REG3, so addr[3:2] is the index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      wr_cnt <= 8'd0;
      rd_cnt <= 8'd0;
    end else if (commit && !err) begin
      if (write) begin
        regs[addr[3:2]] <= wdata;
        wr_cnt          <= wr_cnt + 8'd1;
      end else begin
        rd_cnt <= rd_cnt + 8'd1;
      end
    end
  end

  // STATUS sees the counters as they stand before this read's own increment.
  always_comb begin
    rdata = '0;
    case (sel)
      SEL_REG0:   rdata = regs[0];
      SEL_REG1:   rdata = regs[1];
      SEL_REG2:   rdata = regs[2];
      SEL_REG3:   rdata = regs[3];
      SEL_STATUS: rdata = DATA_WIDTH'({wr_cnt, rd_cnt});
      SEL_ID:     rdata = ID_VALUE;
      default:    rdata = '0;
    endcase
  end

  assign reg_out = {regs[3], regs[2], regs[1], regs[0]};

endmodule

// File: rtl/apb_wait_regbank_slave.sv
// APB completer with a fixed number of wait states per transfer, backed by a
// small register bank (REG0..3 RW, STATUS RO, ID RO).
//   PCLK, PRESET          : clock, asynchronous active-high reset
//   PSEL, PENABLE, PWRITE : APB control from the requester
//   PADDR, PWDATA         : APB address and write data
//   PRDATA                : read data, non-zero only on a good read completion
//   PREADY                : high on the completing access cycle
//   PSLVERR               : error response, only while PREADY is high
//   REG_OUT               : {REG3, REG2, REG1, REG0}
//
// Handshake: a transfer starts with a setup cycle (PSEL=1, PENABLE=0) seen in
// IDLE; the completer then holds PREADY low for WAIT_STATES access cycles
// (PSEL=1, PENABLE=1) and raises it on the next one. The edge at which
// PSEL & PENABLE & PREADY are all high completes the transfer. Dropping PSEL
// during ACCESS abandons the transfer with no side effects.
module apb_wait_regbank_slave
  import apb_regbank_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    WAIT_STATES = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(32'hA9B0_0001)
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [4*DATA_WIDTH-1:0] REG_OUT
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  apb_cmp_state_t        state;
  logic [3:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  write_q;
  logic                  ready;
  logic                  commit;
  logic                  bank_err;
  logic [DATA_WIDTH-1:0] bank_rdata;

  assign ready  = (state == ACCESS) && (wait_cnt == 4'd0);
  assign commit = ready && PSEL && PENABLE;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            addr_q   <= PADDR;
            wdata_q  <= PWDATA;
            write_q  <= PWRITE;
            wait_cnt <= WAIT_INIT;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            state <= IDLE;
          end else if (PENABLE) begin
            if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
            else                  state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  apb_regbank #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ID_VALUE   (ID_VALUE)
  ) u_bank (
    .clk     (PCLK),
    .rst     (PRESET),
    .commit  (commit),
    .addr    (addr_q),
    .wdata   (wdata_q),
    .write   (write_q),
    .rdata   (bank_rdata),
    .err     (bank_err),
    .reg_out (REG_OUT)
  );

  assign PREADY  = ready;
  assign PSLVERR = ready && bank_err;
  assign PRDATA  = (ready && !write_q && !bank_err) ? bank_rdata : '0;

endmodule

// File: tb/tb_apb_wait_regbank_slave.sv
module tb_apb_wait_regbank_slave;

  localparam int          AW = 32;
  localparam int          DW = 32;
  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic          clk = 1'b0;
  logic          rst;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          use0;

  logic          psel1, psel0;
  logic [DW-1:0] prdata1, prdata0;
  logic          pready1, pready0, pslverr1, pslverr0;
  logic [127:0]  reg_out1, reg_out0;

  logic          obs_ready, obs_err;
  logic [DW-1:0] obs_rdata;

  int compared = 0;
  int failed   = 0;

  always #5 clk = ~clk;

  // One shared bus; PSEL is steered to the instance under test.
  assign psel1     = psel && !use0;
  assign psel0     = psel && use0;
  assign obs_ready = use0 ? pready0 : pready1;
  assign obs_err   = use0 ? pslverr0 : pslverr1;
  assign obs_rdata = use0 ? prdata0 : prdata1;

  apb_wait_regbank_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(1), .ID_VALUE(ID)) u_dut1 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel1), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata1), .PREADY(pready1),
    .PSLVERR(pslverr1), .REG_OUT(reg_out1)
  );

  apb_wait_regbank_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(0), .ID_VALUE(ID)) u_dut0 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0),
    .PSLVERR(pslverr0), .REG_OUT(reg_out0)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at #1 after a rising edge; returns at #1 after the completion edge
  // with the bus idle, so a following call starts a setup with no bubble.
  task automatic apb_xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output logic [DW-1:0] rd, output logic er,
                          output int lat, output int waits);
    bit done = 0;
    lat = 0; waits = 0; rd = '0; er = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); lat++;
    #1 penable = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (obs_ready) begin
        rd = obs_rdata; er = obs_err; done = 1;
      end else begin
        waits++;
      end
      @(posedge clk); lat++;
      #1;
    end
    psel = 1'b0; penable = 1'b0;
    if (!done) check("pready_timeout", 1'b0, 1'b1);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  logic [DW-1:0] rd;
  logic          er;
  int            lat, waits;

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; use0 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pready", pready1, 1'b0);
    check("rst_pslverr", pslverr1, 1'b0);
    check("rst_prdata", prdata1, 32'h0);
    check("rst_reg_out", reg_out1, 128'h0);
    @(posedge clk); #1 rst = 1'b0;
    idle_cycle();

    // Write 19 @0x00: one wait cycle, completes 3 edges after setup start.
    apb_xfer(1'b1, 32'h00, 32'd19, rd, er, lat, waits);
    check("w0_err", er, 1'b0);
    check("w0_waits", waits, 1);
    check("w0_latency", lat, 3);
    check("w0_reg0", reg_out1[31:0], 32'd19);
    // wr=1, rd=0 before this read
    apb_xfer(1'b0, 32'h10, 32'h0, rd, er, lat, waits);
    check("status_a", rd, 32'h0000_0100);

    apb_xfer(1'b1, 32'h04, 32'h2412_2023, rd, er, lat, waits);
    check("w4_err", er, 1'b0);
    apb_xfer(1'b0, 32'h04, 32'h0, rd, er, lat, waits);
    check("r4_data", rd, 32'h2412_2023);
    check("r4_err", er, 1'b0);
    // wr=2, rd=2 (status read + reg1 read) before this read
    apb_xfer(1'b0, 32'h10, 32'h0, rd, er, lat, waits);
    check("status_b", rd, 32'h0000_0202);

    apb_xfer(1'b0, 32'h14, 32'h0, rd, er, lat, waits);
    check("r_id", rd, ID);
    check("r_id_err", er, 1'b0);

    // Write to ID is rejected; ID and wr count unchanged.
    apb_xfer(1'b1, 32'h14, 32'hFFFF_FFFF, rd, er, lat, waits);
    check("w_id_err", er, 1'b1);
    check("w_id_prdata", rd, 32'h0);
    // wr=2, rd=4
    apb_xfer(1'b0, 32'h10, 32'h0, rd, er, lat, waits);
    check("status_c", rd, 32'h0000_0204);
    apb_xfer(1'b0, 32'h14, 32'h0, rd, er, lat, waits);
    check("r_id_again", rd, ID);

    // Misaligned write and out-of-range read.
    apb_xfer(1'b1, 32'h02, 32'hBAD0_BAD0, rd, er, lat, waits);
    check("w_misalign_err", er, 1'b1);
    apb_xfer(1'b0, 32'h18, 32'h0, rd, er, lat, waits);
    check("r_range_err", er, 1'b1);
    check("r_range_prdata", rd, 32'h0);
    check("err_no_change", reg_out1, {32'h0, 32'h0, 32'h2412_2023, 32'd19});
    // errored transfers are not counted: wr=2, rd=6
    apb_xfer(1'b0, 32'h10, 32'h0, rd, er, lat, waits);
    check("status_d", rd, 32'h0000_0206);

    // 254 more writes bring wr_cnt from 2 to 256, i.e. wrap to 0. rd=7.
    for (int i = 0; i < 254; i++)
      apb_xfer(1'b1, 32'h08, 32'h100 + i, rd, er, lat, waits);
    apb_xfer(1'b0, 32'h10, 32'h0, rd, er, lat, waits);
    check("status_wrap", rd, 32'h0000_0007);
    check("reg2_last", reg_out1[95:64], 32'h0000_01FD);

    // Reset during an ACCESS wait cycle of a write.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hDEAD_BEEF;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    check("mid_wait_pready", pready1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_pready", pready1, 1'b0);
    check("mid_rst_regs", reg_out1, 128'h0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    idle_cycle();
    check("post_rst_regs", reg_out1, 128'h0);
    apb_xfer(1'b0, 32'h10, 32'h0, rd, er, lat, waits);
    check("post_rst_status", rd, 32'h0);

    // Zero-wait instance: back-to-back writes, 2 edges each, no bubble.
    use0 = 1'b1;
    apb_xfer(1'b1, 32'h00, 32'h0000_0011, rd, er, lat, waits);
    check("ws0_w0_latency", lat, 2);
    check("ws0_w0_waits", waits, 0);
    apb_xfer(1'b1, 32'h0C, 32'h0000_0033, rd, er, lat, waits);
    check("ws0_w3_latency", lat, 2);
    check("ws0_w3_err", er, 1'b0);
    check("ws0_reg_out", reg_out0, {32'h33, 32'h0, 32'h0, 32'h11});
    apb_xfer(1'b0, 32'h0C, 32'h0, rd, er, lat, waits);
    check("ws0_r3_data", rd, 32'h33);
    check("ws0_r3_latency", lat, 2);
    // wr=2, rd=1 before this read
    apb_xfer(1'b0, 32'h10, 32'h0, rd, er, lat, waits);
    check("ws0_status", rd, 32'h0000_0201);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
